// File: rtl/polyvec_coeff_streamer_if.sv
// Coefficient stream bus: registered beat payload with a valid/ready handshake.
interface polyvec_coeff_streamer_if #(
    parameter int ML_KEM_K = 3,
    parameter int LANES    = 4
);
    localparam int PW = $clog2(2 * ML_KEM_K);
    localparam int BW = $clog2(256 / LANES);

    logic                  coef_valid;
    logic                  coef_ready;
    logic [LANES*12-1:0]   coef;
    logic [PW-1:0]         poly_idx;
    logic [BW-1:0]         beat_idx;
    logic                  last_poly;
    logic                  last;

    modport master (
        output coef_valid, coef, poly_idx, beat_idx, last_poly, last,
        input  coef_ready
    );

    modport slave (
        input  coef_valid, coef, poly_idx, beat_idx, last_poly, last,
        output coef_ready
    );
endinterface

// File: rtl/polyvec_coeff_streamer.sv
// Captures a polyvec of 2*ML_KEM_K signed 8-bit noise polynomials and streams the
// coefficients, lifted to their canonical residue mod Q, in LANES-wide beats.
module polyvec_coeff_streamer #(
    parameter int ML_KEM_K = 3,
    parameter int LANES    = 4,
    parameter int Q        = 3329
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                load_i,
    input  logic [2*ML_KEM_K-1:0][255:0][7:0]   polyvec_i,
    output logic                                load_rdy_o,
    output logic                                done_o,
    output logic                                drop_o,
    polyvec_coeff_streamer_if.master            coef_bus
);
    localparam int NPOLY = 2 * ML_KEM_K;
    localparam int BEATS = 256 / LANES;
    localparam int PW    = $clog2(NPOLY);
    localparam int BW    = $clog2(BEATS);
    localparam int LB    = $clog2(LANES);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                         r_state;
    logic [NPOLY-1:0][255:0][7:0]   r_buf;
    logic                           r_load_rdy;
    logic                           r_valid;
    logic [LANES*12-1:0]            r_coef;
    logic [PW-1:0]                  r_poly_idx;
    logic [BW-1:0]                  r_beat_idx;
    logic                           r_last_poly;
    logic                           r_last;
    logic                           r_done;
    logic                           r_drop;

    logic                           w_hs;
    logic                           w_accept;
    logic [BW-1:0]                  w_next_beat;
    logic [PW-1:0]                  w_next_poly;
    logic [255:0][7:0]              w_src;
    logic [LANES*12-1:0]            w_coef;
    logic                           w_next_last_poly;
    logic                           w_next_last;

    // Negative coefficients wrap into [Q-128, Q-1]; the 12-bit add discards the sign extension.
    function automatic logic [11:0] lift(input logic [7:0] c);
        logic [11:0] s;
        s = {{4{c[7]}}, c} + 12'(Q);
        return c[7] ? s : {4'b0000, c};
    endfunction

    always_comb begin
        // NOTE: every signal gets its value before any conditional override, so no latch can form.
        w_hs        = r_valid & coef_bus.coef_ready;
        w_accept    = (r_state == IDLE) & load_i;
        w_next_beat = r_beat_idx + 1'b1;
        w_next_poly = (r_beat_idx == BW'(BEATS - 1)) ? r_poly_idx + 1'b1 : r_poly_idx;
        w_src       = r_buf[w_next_poly];
        if (w_accept) begin
            w_next_beat = '0;
            w_next_poly = '0;
            w_src       = polyvec_i[0];
        end
        w_coef = '0;
        for (int j = 0; j < LANES; j++) begin
            w_coef[j*12 +: 12] = lift(w_src[{w_next_beat, LB'(j)}]);
        end
        w_next_last_poly = (w_next_beat == BW'(BEATS - 1));
        w_next_last      = w_next_last_poly & (w_next_poly == PW'(NPOLY - 1));
    end

    // NOTE: the capture buffer is pure datapath and is never read before a load, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_buf <= polyvec_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_load_rdy  <= 1'b1;
            r_valid     <= 1'b0;
            r_coef      <= '0;
            r_poly_idx  <= '0;
            r_beat_idx  <= '0;
            r_last_poly <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_i) begin
                        r_state     <= STREAM;
                        r_load_rdy  <= 1'b0;
                        r_valid     <= 1'b1;
                        r_coef      <= w_coef;
                        r_poly_idx  <= w_next_poly;
                        r_beat_idx  <= w_next_beat;
                        r_last_poly <= w_next_last_poly;
                        r_last      <= w_next_last;
                    end
                end
                STREAM: begin
                    r_drop <= load_i;
                    if (w_hs) begin
                        if (r_last) begin
                            r_state     <= IDLE;
                            r_load_rdy  <= 1'b1;
                            r_valid     <= 1'b0;
                            r_done      <= 1'b1;
                            r_coef      <= '0;
                            r_poly_idx  <= '0;
                            r_beat_idx  <= '0;
                            r_last_poly <= 1'b0;
                            r_last      <= 1'b0;
                        end else begin
                            r_coef      <= w_coef;
                            r_poly_idx  <= w_next_poly;
                            r_beat_idx  <= w_next_beat;
                            r_last_poly <= w_next_last_poly;
                            r_last      <= w_next_last;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign load_rdy_o          = r_load_rdy;
    assign done_o              = r_done;
    assign drop_o              = r_drop;
    assign coef_bus.coef_valid = r_valid;
    assign coef_bus.coef       = r_coef;
    assign coef_bus.poly_idx   = r_poly_idx;
    assign coef_bus.beat_idx   = r_beat_idx;
    assign coef_bus.last_poly  = r_last_poly;
    assign coef_bus.last       = r_last;
endmodule

// File: tb/tb_polyvec_coeff_streamer.sv
// Scoreboard bench: expected beats are queued at load time and popped on each handshake.
module tb_polyvec_coeff_streamer;
    localparam int K     = 3;
    localparam int LANES = 4;
    localparam int NPOLY = 2 * K;
    localparam int BEATS = 256 / LANES;

    typedef struct {
        logic [47:0] coef;
        int          poly;
        int          beat;
        bit          lp;
        bit          l;
    } beat_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          load = 1'b0;
    logic [NPOLY-1:0][255:0][7:0]  pv;
    logic                          load_rdy;
    logic                          done;
    logic                          drop;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    done_cnt = 0;

    polyvec_coeff_streamer_if #(.ML_KEM_K(K), .LANES(LANES)) bus ();

    polyvec_coeff_streamer #(.ML_KEM_K(K), .LANES(LANES), .Q(3329)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (load),
        .polyvec_i  (pv),
        .load_rdy_o (load_rdy),
        .done_o     (done),
        .drop_o     (drop),
        .coef_bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_lift(input logic [7:0] c);
        int v;
        v = int'($signed(c));
        if (v < 0) v = v + 3329;
        return 12'(v);
    endfunction

    task automatic fill(input int kind);
        for (int p = 0; p < NPOLY; p++) begin
            for (int i = 0; i < 256; i++) begin
                case (kind)
                    0: pv[p][i] = 8'(((p + i) % 7) - 3);
                    1: case (i % 4)
                           0: pv[p][i] = 8'h80;
                           1: pv[p][i] = 8'hFF;
                           2: pv[p][i] = 8'h00;
                           default: pv[p][i] = 8'h7F;
                       endcase
                    default: pv[p][i] = 8'($urandom);
                endcase
            end
        end
    endtask

    task automatic push_expected();
        beat_t e;
        for (int p = 0; p < NPOLY; p++) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int j = 0; j < LANES; j++) e.coef[j*12 +: 12] = ref_lift(pv[p][b*LANES + j]);
                e.poly = p;
                e.beat = b;
                e.lp   = (b == BEATS - 1);
                e.l    = (b == BEATS - 1) && (p == NPOLY - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // mode 0: plain run, 1: loads injected at beat 10 and on the final handshake, 2: reset at beat 200
    task automatic stream(input int ready_pct, input int mode, input bit chk_first,
                          input logic [47:0] first_exp);
        beat_t       e;
        int          n_beats = 0;
        int          bubbles = 0;
        int          cyc = 0;
        bit          final_hs = 0;
        bit          stalled = 0;
        bit          exp_drop = 0;
        bit          injected = 0;
        bit          hs;
        logic [63:0] snap = '0;
        logic [63:0] cur;

        exp_q.delete();
        done_cnt = 0;
        load = 1'b1;
        push_expected();
        @(negedge clk);
        load = 1'b0;
        check("first_valid", bus.coef_valid, 1);
        check("busy_rdy", load_rdy, 0);
        if (chk_first) check("beat0_const", bus.coef, first_exp);

        while (!final_hs && cyc < 3000) begin
            cyc++;
            cur = {4'b0, bus.coef_valid, bus.last, bus.last_poly, bus.poly_idx, bus.beat_idx, bus.coef};
            if (exp_drop) check("drop_mid", drop, 1);
            exp_drop = 0;
            if (done) done_cnt++;
            if (stalled) check("stall_hold", cur, snap);
            if (mode == 2 && n_beats == 200) begin
                rst = 1'b1;
                #1;
                check("abort_valid", bus.coef_valid, 0);
                check("abort_rdy", load_rdy, 1);
                check("abort_coef", bus.coef, 0);
                check("abort_idx", {bus.poly_idx, bus.beat_idx}, 0);
                check("abort_last", {bus.last, bus.last_poly}, 0);
                bus.coef_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
                check("abort_no_done", done_cnt, 0);
                exp_q.delete();
                return;
            end
            if (!bus.coef_valid) bubbles++;
            bus.coef_ready = ($urandom_range(99) < ready_pct);
            hs = bus.coef_valid & bus.coef_ready;
            if (mode == 1 && !injected && n_beats == 10) begin
                load = 1'b1;
                pv[0][0] = ~pv[0][0];
                exp_drop = 1;
                injected = 1;
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("coef", bus.coef, e.coef);
                    check("poly_idx", bus.poly_idx, e.poly);
                    check("beat_idx", bus.beat_idx, e.beat);
                    check("last_poly", bus.last_poly, e.lp);
                    check("last", bus.last, e.l);
                    if (e.l) final_hs = 1;
                end
                n_beats++;
            end
            if (final_hs && mode == 1) begin
                load = 1'b1;
                exp_drop = 1;
            end
            stalled = bus.coef_valid & ~bus.coef_ready;
            snap = cur;
            @(negedge clk);
            load = 1'b0;
        end
        bus.coef_ready = 1'b0;

        if (!final_hs) check("timeout", 0, 1);
        if (exp_drop) check("drop_last", drop, 1);
        check("done_early", done_cnt, 0);
        check("done_pulse", done, 1);
        check("idle_valid", bus.coef_valid, 0);
        check("idle_rdy", load_rdy, 1);
        check("beat_count", n_beats, NPOLY * BEATS);
        check("queue_empty", exp_q.size(), 0);
        if (ready_pct == 100) check("no_bubble", bubbles, 0);
        if (mode != 1) begin
            @(negedge clk);
            check("done_once", done, 0);
            check("drop_quiet", drop, 0);
        end
    endtask

    initial begin
        bus.coef_ready = 1'b0;
        fill(0);
        repeat (2) @(negedge clk);
        check("rst_valid", bus.coef_valid, 0);
        check("rst_rdy", load_rdy, 1);
        check("rst_pulses", {done, drop}, 0);
        check("rst_coef", bus.coef, 0);
        check("rst_idx", {bus.poly_idx, bus.beat_idx, bus.last_poly, bus.last}, 0);
        rst = 1'b0;
        @(negedge clk);

        fill(0);
        stream(100, 0, 1, {12'd0, 12'd3328, 12'd3327, 12'd3326});

        fill(1);
        stream(100, 0, 1, {12'd127, 12'd0, 12'd3328, 12'd3201});

        fill(2);
        stream(50, 0, 0, '0);

        fill(0);
        stream(100, 1, 0, '0);
        fill(2);
        stream(100, 0, 0, '0);

        fill(2);
        stream(100, 2, 0, '0);
        fill(0);
        stream(70, 0, 1, {12'd0, 12'd3328, 12'd3327, 12'd3326});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
